// File: rtl/bus_datapath_if.sv
// Control, memory and observation signals of the single-bus datapath.
// The control unit/bench drives through master; the datapath uses slave.
`timescale 1ns/10ps
interface bus_datapath_if #(
    parameter int WIDTH = 16
);
    logic [2:0]       regSel;
    logic             regRd;
    logic             regWr;
    logic [3:0]       aluSel;
    logic [2:0]       shiftSel;
    logic             workregWr;
    logic             outRegWr;
    logic             outRegRd;
    logic             progCntRd;
    logic             progCntWr;
    logic             addrRegWr;
    logic             ramRd;
    logic             ramWr;
    logic             instrWr;
    logic [WIDTH-1:0] mem_rdata;

    logic [WIDTH-1:0] instrReg;
    logic [WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_wdata;
    logic             mem_rd;
    logic             mem_wr;
    logic [WIDTH-1:0] bus_data;
    logic [WIDTH-1:0] pc_value;
    logic             carry_flag;
    logic             zero_flag;

    modport master (
        output regSel, regRd, regWr, aluSel, shiftSel, workregWr, outRegWr,
               outRegRd, progCntRd, progCntWr, addrRegWr, ramRd, ramWr,
               instrWr, mem_rdata,
        input  instrReg, mem_addr, mem_wdata, mem_rd, mem_wr, bus_data,
               pc_value, carry_flag, zero_flag
    );

    modport slave (
        input  regSel, regRd, regWr, aluSel, shiftSel, workregWr, outRegWr,
               outRegRd, progCntRd, progCntWr, addrRegWr, ramRd, ramWr,
               instrWr, mem_rdata,
        output instrReg, mem_addr, mem_wdata, mem_rd, mem_wr, bus_data,
               pc_value, carry_flag, zero_flag
    );
endinterface

// File: rtl/bus_datapath.sv
// Single-bus accumulator datapath: register file, work/out/pc/addr/ir registers,
// ALU plus shifter, and a zero-latency memory port, all fed from one shared bus.
`timescale 1ns/10ps
module bus_datapath #(
    parameter int WIDTH = 16
) (
    input logic          clock,
    input logic          reset,
    bus_datapath_if.slave dp
);

    logic [WIDTH-1:0] r_regArray [8];
    logic [WIDTH-1:0] r_workReg;
    logic [WIDTH-1:0] r_outReg;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_addrReg;
    logic [WIDTH-1:0] r_ir;
    logic             r_carry;
    logic             r_zero;

    logic [WIDTH-1:0] w_bus;
    logic [WIDTH:0]   w_alu;
    logic [WIDTH-1:0] w_shift;

    // Result in the low WIDTH bits; the extra top bit is carry-out or borrow.
    function automatic logic [WIDTH:0] alu_op(input logic [3:0] sel,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
        logic [WIDTH:0] r;
        case (sel)
            4'd1:    r = {1'b0, a & b};
            4'd2:    r = {1'b0, a | b};
            4'd3:    r = {1'b0, ~b};
            4'd4:    r = {1'b0, a ^ b};
            4'd5:    r = {1'b0, a} + {1'b0, b};
            4'd6:    r = {1'b0, a} - {1'b0, b};
            4'd7:    r = {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};
            4'd8:    r = {1'b0, b} - {{WIDTH{1'b0}}, 1'b1};
            4'd9:    r = '0;
            default: r = {1'b0, b};
        endcase
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] shift_op(input logic [2:0] sel,
                                                  input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (sel)
            3'd1:    r = {v[WIDTH-2:0], 1'b0};
            3'd2:    r = {1'b0, v[WIDTH-1:1]};
            3'd3:    r = {v[WIDTH-2:0], v[WIDTH-1]};
            3'd4:    r = {v[0], v[WIDTH-1:1]};
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        w_bus = '0;
        if (dp.outRegRd)       w_bus = r_outReg;
        else if (dp.ramRd)     w_bus = dp.mem_rdata;
        else if (dp.regRd)     w_bus = r_regArray[dp.regSel];
        else if (dp.progCntRd) w_bus = r_pc;
    end

    assign w_alu   = alu_op(dp.aluSel, r_workReg, w_bus);
    assign w_shift = shift_op(dp.shiftSel, w_alu[WIDTH-1:0]);

    // All enabled targets load from the same pre-edge bus value.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) r_regArray[i] <= '0;
            r_workReg <= '0;
            r_outReg  <= '0;
            r_pc      <= '0;
            r_addrReg <= '0;
            r_ir      <= '0;
            r_carry   <= 1'b0;
            r_zero    <= 1'b0;
        end else begin
            if (dp.regWr)     r_regArray[dp.regSel] <= w_bus;
            if (dp.workregWr) r_workReg <= w_bus;
            if (dp.progCntWr) r_pc      <= w_bus;
            if (dp.addrRegWr) r_addrReg <= w_bus;
            if (dp.instrWr)   r_ir      <= w_bus;
            if (dp.outRegWr) begin
                r_outReg <= w_shift;
                r_carry  <= w_alu[WIDTH];
                r_zero   <= (w_shift == '0);
            end
        end
    end

    assign dp.instrReg   = r_ir;
    assign dp.mem_addr   = r_addrReg;
    assign dp.mem_wdata  = w_bus;
    assign dp.mem_rd     = dp.ramRd;
    assign dp.mem_wr     = dp.ramWr;
    assign dp.bus_data   = w_bus;
    assign dp.pc_value   = r_pc;
    assign dp.carry_flag = r_carry;
    assign dp.zero_flag  = r_zero;

endmodule

// File: tb/tb_bus_datapath.sv
// Bench for bus_datapath: ALU/shifter vector table, directed multi-cycle scenarios
// and a randomized run against an arithmetic reference model.
`timescale 1ns/10ps
module tb_bus_datapath;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bus_datapath_if #(.WIDTH(16)) bif();
    bus_datapath #(.WIDTH(16)) dut (.clock(clock), .reset(reset), .dp(bif));

    int checks = 0;
    int errors = 0;

    int m_reg [8];
    int m_work, m_out, m_pc, m_addr, m_ir, m_c, m_z;

    typedef struct {
        logic [3:0]  op;
        logic [2:0]  sh;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        c;
        logic        z;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bif.regSel = 3'd0;  bif.regRd = 1'b0;  bif.regWr = 1'b0;
        bif.aluSel = 4'd0;  bif.shiftSel = 3'd0;
        bif.workregWr = 1'b0; bif.outRegWr = 1'b0; bif.outRegRd = 1'b0;
        bif.progCntRd = 1'b0; bif.progCntWr = 1'b0; bif.addrRegWr = 1'b0;
        bif.ramRd = 1'b0; bif.ramWr = 1'b0; bif.instrWr = 1'b0;
        bif.mem_rdata = 16'h0000;
    endtask

    task automatic m_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 0;
        m_work = 0; m_out = 0; m_pc = 0; m_addr = 0; m_ir = 0; m_c = 0; m_z = 0;
    endtask

    function automatic int m_bus();
        if (bif.outRegRd)  return m_out;
        if (bif.ramRd)     return int'(bif.mem_rdata);
        if (bif.regRd)     return m_reg[bif.regSel];
        if (bif.progCntRd) return m_pc;
        return 0;
    endfunction

    // Returns shifted result in bits 15:0 and carry/borrow in bit 16.
    function automatic int model_calc(input int a, input int b, input int op, input int sh);
        int r;
        int c;
        r = b; c = 0;
        case (op)
            1: r = a & b;
            2: r = a | b;
            3: r = (~b) & 65535;
            4: r = a ^ b;
            5: begin r = a + b; c = (r > 65535) ? 1 : 0; r = r & 65535; end
            6: begin c = (a < b) ? 1 : 0; r = (a - b) & 65535; end
            7: begin c = (b == 65535) ? 1 : 0; r = (b + 1) & 65535; end
            8: begin c = (b == 0) ? 1 : 0; r = (b - 1) & 65535; end
            9: r = 0;
            default: r = b;
        endcase
        case (sh)
            1: r = (r * 2) & 65535;
            2: r = r / 2;
            3: r = ((r * 2) & 65535) | (r / 32768);
            4: r = (r / 2) | ((r % 2) * 32768);
            default: ;
        endcase
        return r | (c << 16);
    endfunction

    task automatic m_edge();
        int b;
        int v;
        b = m_bus();
        v = model_calc(m_work, b, int'(bif.aluSel), int'(bif.shiftSel));
        if (bif.outRegWr) begin
            m_out = v & 65535;
            m_c   = v >> 16;
            m_z   = ((v & 65535) == 0) ? 1 : 0;
        end
        if (bif.regWr)     m_reg[bif.regSel] = b;
        if (bif.workregWr) m_work = b;
        if (bif.progCntWr) m_pc = b;
        if (bif.addrRegWr) m_addr = b;
        if (bif.instrWr)   m_ir = b;
    endtask

    task automatic step();
        m_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic mem_load(input logic [15:0] v);
        idle(); bif.ramRd = 1'b1; bif.mem_rdata = v;
    endtask

    task automatic read_reg(input logic [2:0] idx);
        idle(); bif.regRd = 1'b1; bif.regSel = idx;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{4'd5,  3'd0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
        tbl[1]  = '{4'd5,  3'd0, 16'h1234, 16'h0F0F, 16'h2143, 1'b0, 1'b0};
        tbl[2]  = '{4'd7,  3'd0, 16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b1};
        tbl[3]  = '{4'd8,  3'd0, 16'h0000, 16'h0000, 16'hFFFF, 1'b1, 1'b0};
        tbl[4]  = '{4'd6,  3'd0, 16'h0001, 16'h0002, 16'hFFFF, 1'b1, 1'b0};
        tbl[5]  = '{4'd6,  3'd0, 16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0};
        tbl[6]  = '{4'd0,  3'd3, 16'h0000, 16'h8001, 16'h0003, 1'b0, 1'b0};
        tbl[7]  = '{4'd0,  3'd4, 16'h0000, 16'h8001, 16'hC000, 1'b0, 1'b0};
        tbl[8]  = '{4'd1,  3'd1, 16'hF0F0, 16'hFF00, 16'hE000, 1'b0, 1'b0};
        tbl[9]  = '{4'd2,  3'd2, 16'h00F0, 16'h0F00, 16'h07F8, 1'b0, 1'b0};
        tbl[10] = '{4'd3,  3'd0, 16'h1111, 16'h00FF, 16'hFF00, 1'b0, 1'b0};
        tbl[11] = '{4'd4,  3'd0, 16'hAAAA, 16'hAAAA, 16'h0000, 1'b0, 1'b1};
        tbl[12] = '{4'd9,  3'd0, 16'h5555, 16'h1234, 16'h0000, 1'b0, 1'b1};
        tbl[13] = '{4'd12, 3'd5, 16'h0001, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0};
        tbl[14] = '{4'd0,  3'd1, 16'h0000, 16'h8000, 16'h0000, 1'b0, 1'b1};
        tbl[15] = '{4'd7,  3'd0, 16'h0000, 16'h0041, 16'h0042, 1'b0, 1'b0};

        // Reset state
        idle();
        reset = 1'b1;
        m_reset();
        #12;
        reset = 1'b0;
        #1;
        chk("rst_bus",   32'(bif.bus_data), 32'h0);
        chk("rst_addr",  32'(bif.mem_addr), 32'h0);
        chk("rst_ir",    32'(bif.instrReg), 32'h0);
        chk("rst_pc",    32'(bif.pc_value), 32'h0);
        chk("rst_carry", 32'(bif.carry_flag), 32'h0);
        chk("rst_zero",  32'(bif.zero_flag), 32'h0);

        // ALU / shifter vector table
        for (int i = 0; i < 16; i++) begin
            mem_load(tbl[i].a); bif.workregWr = 1'b1; step();
            mem_load(tbl[i].b); bif.aluSel = tbl[i].op; bif.shiftSel = tbl[i].sh;
            bif.outRegWr = 1'b1; step();
            idle(); bif.outRegRd = 1'b1; #1;
            chk($sformatf("vec%0d_out", i), 32'(bif.bus_data), 32'(tbl[i].res));
            chk($sformatf("vec%0d_c", i), 32'(bif.carry_flag), 32'(tbl[i].c));
            chk($sformatf("vec%0d_z", i), 32'(bif.zero_flag), 32'(tbl[i].z));
        end

        // PC increment through the ALU
        mem_load(16'h0005); bif.progCntWr = 1'b1; step();
        idle(); bif.progCntRd = 1'b1; bif.aluSel = 4'd7; bif.outRegWr = 1'b1; step();
        idle(); bif.outRegRd = 1'b1; bif.progCntWr = 1'b1; bif.addrRegWr = 1'b1; step();
        chk("pcinc_pc",   32'(bif.pc_value), 32'h0006);
        chk("pcinc_addr", 32'(bif.mem_addr), 32'h0006);

        // Register add R1 + R2 -> R3
        mem_load(16'h1234); bif.regWr = 1'b1; bif.regSel = 3'd1; step();
        mem_load(16'h0F0F); bif.regWr = 1'b1; bif.regSel = 3'd2; step();
        read_reg(3'd1); bif.workregWr = 1'b1; step();
        read_reg(3'd2); bif.aluSel = 4'd5; bif.outRegWr = 1'b1; step();
        idle(); bif.outRegRd = 1'b1; bif.regWr = 1'b1; bif.regSel = 3'd3; step();
        read_reg(3'd3); #1;
        chk("add_r3",    32'(bif.bus_data), 32'h2143);
        chk("add_carry", 32'(bif.carry_flag), 32'h0);
        chk("add_zero",  32'(bif.zero_flag), 32'h0);

        // Same-register read and write: old value on bus, written back at edge
        read_reg(3'd2); bif.regWr = 1'b1; bif.workregWr = 1'b1; #1;
        chk("rdwr_bus", 32'(bif.bus_data), 32'h0F0F);
        step();

        // Memory load into R6
        mem_load(16'h0010); bif.addrRegWr = 1'b1; step();
        chk("ld_addr", 32'(bif.mem_addr), 32'h0010);
        mem_load(16'hBEEF); bif.regWr = 1'b1; bif.regSel = 3'd6; #1;
        chk("ld_memrd", 32'(bif.mem_rd), 32'h1);
        step();
        read_reg(3'd6); #1;
        chk("ld_r6", 32'(bif.bus_data), 32'hBEEF);

        // ramWr together with ramRd mirrors the read data
        mem_load(16'h7E57); bif.ramWr = 1'b1; #1;
        chk("rw_wdata", 32'(bif.mem_wdata), 32'h7E57);
        chk("rw_memwr", 32'(bif.mem_wr), 32'h1);

        // Bus priority: outReg beats pc
        mem_load(16'h0000); bif.aluSel = 4'd9; bif.outRegWr = 1'b1; step();
        mem_load(16'h0042); bif.progCntWr = 1'b1; step();
        idle(); bif.outRegRd = 1'b1; bif.progCntRd = 1'b1; bif.addrRegWr = 1'b1; step();
        chk("prio_addr", 32'(bif.mem_addr), 32'h0000);
        idle(); bif.progCntRd = 1'b1; bif.regRd = 1'b1; bif.regSel = 3'd6; #1;
        chk("prio_reg_over_pc", 32'(bif.bus_data), 32'hBEEF);

        // Randomized run against the model, with occasional async reset pulses
        for (int n = 0; n < 400; n++) begin
            idle();
            bif.regSel    = 3'($urandom_range(7, 0));
            bif.aluSel    = 4'($urandom_range(15, 0));
            bif.shiftSel  = 3'($urandom_range(7, 0));
            bif.outRegRd  = ($urandom_range(5, 0) == 0);
            bif.ramRd     = ($urandom_range(3, 0) == 0);
            bif.regRd     = ($urandom_range(2, 0) == 0);
            bif.progCntRd = ($urandom_range(3, 0) == 0);
            bif.regWr     = ($urandom_range(2, 0) == 0);
            bif.workregWr = ($urandom_range(2, 0) == 0);
            bif.outRegWr  = ($urandom_range(2, 0) == 0);
            bif.progCntWr = ($urandom_range(3, 0) == 0);
            bif.addrRegWr = ($urandom_range(3, 0) == 0);
            bif.instrWr   = ($urandom_range(3, 0) == 0);
            bif.ramWr     = 1'($urandom_range(1, 0));
            bif.mem_rdata = 16'($urandom);
            #1;
            chk("rnd_bus",   32'(bif.bus_data),  32'(m_bus()));
            chk("rnd_wdata", 32'(bif.mem_wdata), 32'(m_bus()));
            chk("rnd_memwr", 32'(bif.mem_wr),    32'(bif.ramWr));
            step();
            chk("rnd_pc",    32'(bif.pc_value),   32'(m_pc));
            chk("rnd_addr",  32'(bif.mem_addr),   32'(m_addr));
            chk("rnd_ir",    32'(bif.instrReg),   32'(m_ir));
            chk("rnd_carry", 32'(bif.carry_flag), 32'(m_c));
            chk("rnd_zero",  32'(bif.zero_flag),  32'(m_z));
            if ($urandom_range(39, 0) == 0) begin
                #2 reset = 1'b1;
                m_reset();
                #1 reset = 1'b0;
            end
        end

        // Shifter rotate then async reset mid-cycle clears everything before the edge
        for (int i = 0; i < 8; i++) begin
            mem_load(16'hA5A5); bif.regWr = 1'b1; bif.regSel = 3'(i);
            bif.progCntWr = 1'b1; bif.addrRegWr = 1'b1; bif.instrWr = 1'b1;
            bif.workregWr = 1'b1; step();
        end
        mem_load(16'h8001); bif.aluSel = 4'd0; bif.shiftSel = 3'd3; bif.outRegWr = 1'b1; step();
        idle(); bif.outRegRd = 1'b1; #1;
        chk("rot_out", 32'(bif.bus_data), 32'h0003);
        #1 reset = 1'b1;
        m_reset();
        #0.5;
        chk("mid_out",   32'(bif.bus_data),   32'h0);
        chk("mid_pc",    32'(bif.pc_value),   32'h0);
        chk("mid_addr",  32'(bif.mem_addr),   32'h0);
        chk("mid_ir",    32'(bif.instrReg),   32'h0);
        for (int i = 0; i < 8; i++) begin
            read_reg(3'(i)); #0.5;
            chk($sformatf("mid_r%0d", i), 32'(bif.bus_data), 32'h0);
        end
        idle();
        #0.5 reset = 1'b0;
        step();
        mem_load(16'h0007); bif.aluSel = 4'd5; bif.outRegWr = 1'b1; step();
        idle(); bif.outRegRd = 1'b1; #1;
        chk("mid_work", 32'(bif.bus_data), 32'h0007);

        // Reset pulse discards the pending write of that cycle
        mem_load(16'hBEEF); bif.regWr = 1'b1; bif.regSel = 3'd5;
        #2 reset = 1'b1;
        m_reset();
        #1 reset = 1'b0;
        idle();
        step();
        read_reg(3'd5); #1;
        chk("pend_r5", 32'(bif.bus_data), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_datapath.md
BUS_DATAPATH -- requirements
Module: bus_datapath

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting the data, bus and address width; all widths below assume 16.
REQ-002 Port clock SHALL be an input of 1 bit, the system clock; all state updates occur on its rising edge.
REQ-003 Port reset SHALL be an input of 1 bit, asynchronous, active-high.
REQ-004 Port regSel SHALL be an input of 3 bits selecting the register-array entry to read or write.
REQ-005 Ports regRd and regWr SHALL be 1-bit inputs: register-array drive-bus enable and write enable.
REQ-006 Port aluSel SHALL be a 4-bit input selecting the ALU operation.
REQ-007 Port shiftSel SHALL be a 3-bit input selecting the shifter operation.
REQ-008 Ports workregWr, outRegWr, outRegRd, progCntRd, progCntWr and addrRegWr SHALL be 1-bit inputs with the meanings given in REQ-013 and REQ-014.
REQ-009 Ports ramRd, ramWr and instrWr SHALL be 1-bit inputs: memory read, memory write and instruction-register write.
REQ-010 Port mem_rdata SHALL be a 16-bit input carrying memory read data, combinationally valid for mem_addr.
REQ-011 The block SHALL provide these outputs:
- instrReg, 16 bits: instruction-register contents to the control unit.
- mem_addr, 16 bits: equals addrReg.
- mem_wdata, 16 bits: equals the bus.
- mem_rd and mem_wr, 1 bit each: equal ramRd and ramWr.
- bus_data, 16 bits: current bus value.
- pc_value, 16 bits: program counter.
- carry_flag and zero_flag, 1 bit each: ALU flags.

Function
REQ-012 Internal storage SHALL be:
- regArray: 8 entries of 16 bits.
- workReg, outReg, pc, addrReg, ir: 16 bits each.
- carry_flag and zero_flag: 1 bit each.
REQ-013 The single shared bus SHALL be combinational and driven by one source, chosen in this priority order:
- outRegRd: outReg.
- ramRd: mem_rdata.
- regRd: regArray[regSel].
- progCntRd: pc.
- None of these asserted: 16'h0000.
REQ-014 On each rising edge, every asserted write enable SHALL load its target from the bus value of that cycle:
- regWr: regArray[regSel].
- workregWr: workReg.
- progCntWr: pc.
- addrRegWr: addrReg.
- instrWr: ir.
REQ-015 outRegWr SHALL load outReg with shifter(alu(workReg, bus)).
REQ-016 Several simultaneous write enables SHALL all take effect in the same edge, each from the same bus value.
REQ-017 The ALU SHALL compute, with A = workReg and B = bus, truncating to 16 bits:
- 0: pass B.
- 1: A & B.
- 2: A | B.
- 3: ~B.
- 4: A ^ B.
- 5: A + B.
- 6: A - B.
- 7: B + 1.
- 8: B - 1.
- 9: 0.
- 10 to 15: pass B.
REQ-018 The shifter SHALL operate on the ALU result:
- 0: pass.
- 1: shift left logical, LSB = 0.
- 2: shift right logical, MSB = 0.
- 3: rotate left 1.
- 4: rotate right 1.
- 5 to 7: pass.
REQ-019 On outRegWr, carry_flag SHALL load:
- Carry-out of bit 15 for codes 5 and 7.
- Borrow for codes 6 and 8, i.e. 1 when A < B (code 6) or B == 0 (code 8).
- 0 for all other codes.
REQ-020 On outRegWr, zero_flag SHALL load 1 exactly when the shifter output is 16'h0000; neither flag changes without outRegWr.
REQ-021 Wrap-around SHALL be silent: 16'hFFFF inc gives 16'h0000 with carry 1; 16'h0000 dec gives 16'hFFFF with carry 1.
REQ-022 Memory read SHALL be zero-latency: mem_rdata sampled in the same cycle ramRd is asserted, addressed by the addrReg value loaded at an earlier edge.
REQ-023 Simultaneous regWr and regRd to the same regSel SHALL read the old value and write at the edge.
REQ-024 ramWr together with ramRd SHALL present the mem_rdata-driven bus on mem_wdata; no error is flagged.

Reset
REQ-025 Asserting reset SHALL immediately clear regArray, workReg, outReg, pc, addrReg, ir, carry_flag and zero_flag to 0, independent of clock.
REQ-026 Reset asserted mid-operation SHALL discard any pending write; the first edge after deassertion SHALL apply only the enables present at that edge.
REQ-027 With all enables low after reset, bus_data SHALL be 16'h0000, mem_addr 16'h0000 and instrReg 16'h0000.

Verification
REQ-028 Scenario 1, PC increment:
- Stimulus: pc = 16'h0005; progCntRd + aluSel 7 + shiftSel 0 + outRegWr; then outRegRd + progCntWr + addrRegWr.
- Required: pc = mem_addr = 16'h0006.
REQ-029 Scenario 2, register add:
- Stimulus: R1 = 16'h1234, R2 = 16'h0F0F; regRd R1 + workregWr; regRd R2 + aluSel 5 + outRegWr; outRegRd + regWr regSel 3.
- Required: R3 = 16'h2143, carry 0, zero 0.
REQ-030 Scenario 3, overflow:
- Stimulus: workReg = 16'hFFFF, bus = 16'h0001, aluSel 5, outRegWr.
- Required: outReg = 16'h0000, carry 1, zero 1.
REQ-031 Scenario 4, load from memory:
- Stimulus: addrReg = 16'h0010, mem_rdata = 16'hBEEF, ramRd + regWr regSel 6.
- Required: R6 = 16'hBEEF, mem_rd = 1.
REQ-032 Scenario 5, bus priority:
- Stimulus: outReg = 16'h0000, pc = 16'h0042; outRegRd + progCntRd + addrRegWr together.
- Required: addrReg = 16'h0000.
REQ-033 Scenario 6, shifter and reset:
- Stimulus: aluSel 0, bus = 16'h8001, shiftSel 3, outRegWr; then reset pulsed mid-cycle.
- Required: outReg = 16'h0003; after reset, all state = 0 before the next edge.
